// File: rtl/fir_serial.sv
// rtl/fir_serial.sv - 7-tap serial FIR, one multiplier and one adder, 8 cycles per sample.
// Optional saturating accumulator: define FIR_SERIAL_SAT_EN.
module fir_serial (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  Xin,
  input  logic        Xin_valid,
  output logic        Xin_ready,
  input  logic [7:0]  B0,
  input  logic [7:0]  B1,
  input  logic [7:0]  B2,
  input  logic [7:0]  B3,
  input  logic [7:0]  B4,
  input  logic [7:0]  B5,
  input  logic [7:0]  B6,
  output logic [15:0] Yout,
  output logic        Yout_valid
);

  typedef enum logic {IDLE = 1'b0, MAC = 1'b1} state_t;

  state_t      state;
  logic [7:0]  x_dly [0:6];
  logic [7:0]  coef  [0:6];
  logic [15:0] acc;
  logic [2:0]  tap;

  logic [7:0]  x_sel;
  logic [7:0]  b_sel;
  logic [15:0] product;
  logic [15:0] term;
  logic [15:0] sum;
`ifdef FIR_SERIAL_SAT_EN
  logic [16:0] sum_wide;
`endif

  always_comb begin
    x_sel = 8'd0;
    b_sel = 8'd0;
    case (tap)
      3'd0: begin x_sel = x_dly[0]; b_sel = coef[0]; end
      3'd1: begin x_sel = x_dly[1]; b_sel = coef[1]; end
      3'd2: begin x_sel = x_dly[2]; b_sel = coef[2]; end
      3'd3: begin x_sel = x_dly[3]; b_sel = coef[3]; end
      3'd4: begin x_sel = x_dly[4]; b_sel = coef[4]; end
      3'd5: begin x_sel = x_dly[5]; b_sel = coef[5]; end
      3'd6: begin x_sel = x_dly[6]; b_sel = coef[6]; end
      default: begin x_sel = 8'd0; b_sel = 8'd0; end
    endcase
    // Q5.3 * Q2.6 gives Q7.9; dropping one fraction bit aligns it to Q8.8.
    product = 16'(x_sel) * 16'(b_sel);
    term    = {1'b0, product[15:1]};
`ifdef FIR_SERIAL_SAT_EN
    sum_wide = {1'b0, acc} + {1'b0, term};
    sum      = sum_wide[16] ? 16'hFFFF : sum_wide[15:0];
`else
    sum      = acc + term;
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= IDLE;
      acc        <= 16'd0;
      tap        <= 3'd0;
      Yout       <= 16'd0;
      Yout_valid <= 1'b0;
      Xin_ready  <= 1'b1;
      for (int i = 0; i < 7; i++) begin
        x_dly[i] <= 8'd0;
        coef[i]  <= 8'd0;
      end
    end else begin
      Yout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Xin_valid) begin
            x_dly[0] <= Xin;
            for (int i = 1; i < 7; i++) x_dly[i] <= x_dly[i-1];
            coef[0]   <= B0;
            coef[1]   <= B1;
            coef[2]   <= B2;
            coef[3]   <= B3;
            coef[4]   <= B4;
            coef[5]   <= B5;
            coef[6]   <= B6;
            acc       <= 16'd0;
            tap       <= 3'd0;
            state     <= MAC;
            Xin_ready <= 1'b0;
          end
        end
        MAC: begin
          if (tap == 3'd6) begin
            Yout       <= sum;
            Yout_valid <= 1'b1;
            Xin_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            acc <= sum;
            tap <= tap + 3'd1;
          end
        end
        default: begin
          state     <= IDLE;
          Xin_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial.sv
// tb/tb_fir_serial.sv - table-driven checks for fir_serial (wrap or FIR_SERIAL_SAT_EN build).
module tb_fir_serial;

  logic        Clk;
  logic        Rst_n;
  logic [7:0]  Xin;
  logic        Xin_valid;
  logic        Xin_ready;
  logic [7:0]  B0, B1, B2, B3, B4, B5, B6;
  logic [15:0] Yout;
  logic        Yout_valid;

  fir_serial dut (
    .Clk(Clk), .Rst_n(Rst_n), .Xin(Xin), .Xin_valid(Xin_valid), .Xin_ready(Xin_ready),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6),
    .Yout(Yout), .Yout_valid(Yout_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic            rst;
    logic [7:0]      x;
    logic [6:0][7:0] b;
    logic [15:0]     exp;
  } vec_t;

  vec_t vecs [0:31];
  int   nvec = 0;
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic [7:0] x, input logic [6:0][7:0] b,
                     input logic [15:0] exp);
    vecs[nvec].rst = rst;
    vecs[nvec].x   = x;
    vecs[nvec].b   = b;
    vecs[nvec].exp = exp;
    nvec++;
  endtask

  task automatic set_b(input logic [6:0][7:0] b);
    B0 = b[0]; B1 = b[1]; B2 = b[2]; B3 = b[3]; B4 = b[4]; B5 = b[5]; B6 = b[6];
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    Xin_valid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
  endtask

  // Present one sample, wait for the result, check latency and value.
  task automatic send(input logic [7:0] x, input logic [15:0] exp, input string name,
                      input logic chg);
    int w;
    int lat;
    w = 0;
    while (!Xin_ready && w < 20) begin
      @(posedge Clk); #1;
      w++;
    end
    check({name, "_ready"}, 32'(Xin_ready), 32'd1);
    Xin = x;
    Xin_valid = 1'b1;
    @(posedge Clk); #1;
    Xin_valid = 1'b0;
    Xin = 8'hA5;
    lat = 0;
    while (!Yout_valid && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
      if (chg && lat == 2) set_b({7{8'hFF}});
    end
    check({name, "_lat"}, 32'(lat), 32'd7);
    check({name, "_y"}, 32'(Yout), 32'(exp));
    check({name, "_rdy_at_valid"}, 32'(Xin_ready), 32'd1);
    @(posedge Clk); #1;
    check({name, "_pulse"}, 32'(Yout_valid), 32'd0);
    check({name, "_hold"}, 32'(Yout), 32'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] q [$];
    logic [7:0] nx;
    logic [7:0] ex;
    logic       acc_now;
    int         last_acc;
    int         lowcnt;
    int         nacc;
    int         nout;

    Rst_n = 1'b0; Xin = 8'd0; Xin_valid = 1'b0;
    set_b('0);

    // Impulse
    add(1'b1, 8'h08, 56'h00000000002040, 16'h0100);
    add(1'b0, 8'h00, 56'h00000000002040, 16'h0080);
    add(1'b0, 8'h00, 56'h00000000002040, 16'h0000);
    // Step
    add(1'b1, 8'h08, {7{8'h40}}, 16'h0100);
    add(1'b0, 8'h08, {7{8'h40}}, 16'h0200);
    add(1'b0, 8'h08, {7{8'h40}}, 16'h0300);
    add(1'b0, 8'h08, {7{8'h40}}, 16'h0400);
    add(1'b0, 8'h08, {7{8'h40}}, 16'h0500);
    add(1'b0, 8'h08, {7{8'h40}}, 16'h0600);
    add(1'b0, 8'h08, {7{8'h40}}, 16'h0700);
    add(1'b0, 8'h08, {7{8'h40}}, 16'h0700);
    // Overflow: each term is 0x7F00
    add(1'b1, 8'hFF, {7{8'hFF}}, 16'h7F00);
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'hFE00);
`ifdef FIR_SERIAL_SAT_EN
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'hFFFF);
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'hFFFF);
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'hFFFF);
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'hFFFF);
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'hFFFF);
`else
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'h7D00);
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'hFC00);
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'h7B00);
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'hFA00);
    add(1'b0, 8'hFF, {7{8'hFF}}, 16'h7900);
`endif

    do_reset();
    check("reset_ready", 32'(Xin_ready), 32'd1);
    check("reset_valid", 32'(Yout_valid), 32'd0);
    check("reset_yout", 32'(Yout), 32'd0);

    for (int i = 0; i < nvec; i++) begin
      if (vecs[i].rst) do_reset();
      set_b(vecs[i].b);
      send(vecs[i].x, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
    end

    // Back-pressure: Xin_valid held high, Xin advances only on acceptance.
    do_reset();
    set_b(56'h00000000000040);
    nx = 8'h01; Xin = nx; Xin_valid = 1'b1;
    last_acc = -1; lowcnt = 0; nacc = 0; nout = 0;
    for (int c = 0; c < 60; c++) begin
      acc_now = Xin_ready && Xin_valid;
      @(posedge Clk); #1;
      if (acc_now) begin
        q.push_back(Xin);
        if (last_acc >= 0) begin
          check("bp_gap", 32'(c - last_acc), 32'd8);
          check("bp_ready_low", 32'(lowcnt), 32'd7);
        end
        last_acc = c;
        lowcnt = 0;
        nacc++;
        nx = nx + 8'd1;
        Xin = nx;
        if (nacc == 5) Xin_valid = 1'b0;
      end
      if (!Xin_ready) lowcnt++;
      if (Yout_valid) begin
        ex = (q.size() > 0) ? q.pop_front() : 8'h00;
        check("bp_y", 32'(Yout), 32'({3'b000, ex, 5'b00000}));
        nout++;
      end
    end
    check("bp_accepts", 32'(nacc), 32'd5);
    check("bp_outputs", 32'(nout), 32'd5);

    // Reset at k=3 aborts the sample and clears history.
    do_reset();
    set_b(56'h00000000002040);
    Xin = 8'h08; Xin_valid = 1'b1;
    @(posedge Clk); #1;
    Xin_valid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    check("mid_rst_valid", 32'(Yout_valid), 32'd0);
    check("mid_rst_yout", 32'(Yout), 32'd0);
    check("mid_rst_ready", 32'(Xin_ready), 32'd1);
    nout = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #1;
      if (Yout_valid) nout++;
    end
    check("mid_rst_no_pulse", 32'(nout), 32'd0);
    send(8'h08, 16'h0100, "post_rst0", 1'b0);
    send(8'h00, 16'h0080, "post_rst1", 1'b0);

    // Coefficients changed at k=2 must not disturb the running sample.
    do_reset();
    set_b({7{8'h40}});
    send(8'h08, 16'h0100, "chg0", 1'b0);
    send(8'h08, 16'h0200, "chg1", 1'b0);
    send(8'h08, 16'h0300, "chg2", 1'b0);
    send(8'h08, 16'h0400, "chg3", 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fir_serial.md
FIR_SERIAL -- requirements
Module: fir_serial

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port Rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port Xin, input, 8 bits: input sample, unsigned Q5.3.
REQ-004 SHALL have port Xin_valid, input, 1 bit: Xin holds a sample.
REQ-005 SHALL have port Xin_ready, output, 1 bit: block can accept a sample this cycle.
REQ-006 SHALL have ports B0..B6, input, 8 bits each: tap coefficients, unsigned Q2.6; B0 weights the newest sample.
REQ-007 SHALL have port Yout, output, 16 bits: filtered result, unsigned Q8.8.
REQ-008 SHALL have port Yout_valid, output, 1 bit: one-cycle pulse when Yout is updated.

Function
REQ-009 SHALL implement a direct-form 7-tap FIR, folded onto one multiplier and one adder: y[n] = sum over k=0..6 of Bk * x[n-k].
REQ-010 SHALL keep a 7-entry sample delay line x[0..6] of 8 bits each.
REQ-011 SHALL use a two-state FSM: IDLE and MAC.
REQ-012 In IDLE, SHALL drive Xin_ready=1.
REQ-013 In MAC, SHALL drive Xin_ready=0.
REQ-014 On an IDLE cycle with Xin_valid=1, SHALL do all of the following at that edge: shift the delay line (x[0]<=Xin, x[k]<=x[k-1]), latch B0..B6 into a coefficient register, clear the accumulator, clear the tap counter, and go to MAC.
REQ-015 In IDLE with Xin_valid=0, SHALL hold all state.
REQ-016 In MAC, SHALL spend exactly 7 cycles, with tap counter k=0..6.
REQ-017 On each MAC cycle, SHALL compute term = (x[k] * Bk_latched) as a 16-bit Q7.9 product, shift it right by 1 with zero fill to give Q8.8, and add it to the 16-bit accumulator.
REQ-018 Accumulator addition SHALL wrap modulo 2^16 when SAT_EN is not defined (see Configuration).
REQ-019 On the k=6 edge, SHALL set Yout <= accumulator + term and Yout_valid <= 1, and return to IDLE.
REQ-020 Yout_valid SHALL be high for exactly one cycle per accepted sample; otherwise it is 0.
REQ-021 Yout SHALL hold its value between updates.
REQ-022 Latency SHALL be 7 cycles: Yout_valid is high in the 7th cycle after the acceptance cycle.
REQ-023 Maximum throughput SHALL be one sample per 8 cycles.
REQ-024 Xin_ready SHALL be 1 in the same cycle that Yout_valid is 1.
REQ-025 A sample presented while Xin_ready=0 SHALL NOT be captured; the source holds it until accepted.
REQ-026 Changes on B0..B6 during MAC SHALL NOT affect the result in progress.
REQ-027 The tap counter SHALL never exceed 6; there is no wrap condition inside MAC.

Reset
REQ-028 While Rst_n=0 at a clock edge, SHALL set the FSM to IDLE, and the delay line, coefficient register, accumulator, tap counter, Yout and Yout_valid to 0.
REQ-029 Xin_ready SHALL be 1 in the first cycle after reset is released.
REQ-030 Reset asserted during MAC SHALL abort the computation with no Yout_valid pulse and no Yout change other than clearing to 0.
REQ-031 Reset SHALL take priority over a simultaneous Xin_valid handshake.

Configuration
REQ-032 When macro FIR_SERIAL_SAT_EN is defined, the accumulator SHALL saturate: if a 17-bit sum exceeds 16'hFFFF, the accumulator becomes 16'hFFFF and stays saturated for the rest of that sample.
REQ-033 When FIR_SERIAL_SAT_EN is undefined, addition SHALL wrap modulo 2^16; latency and handshake are identical in both builds.

Verification
REQ-034 Impulse: B0=0x40, B1=0x20, others 0, history zero; feed Xin=0x08, then 0x00 -> Yout=0x0100, then 0x0080, then 0x0000.
REQ-035 Step: all Bk=0x40, Xin=0x08 for 8 samples -> Yout=0x0100, 0x0200, ... 0x0700, 0x0700.
REQ-036 Overflow: all Bk=0xFF, Xin=0xFF for 7 samples -> 7th Yout=0x7900 without FIR_SERIAL_SAT_EN, 0xFFFF with it; 2nd Yout=0xFE00 in both builds.
REQ-037 Back-pressure: hold Xin_valid=1 with an incrementing Xin -> exactly one acceptance per 8 cycles, Xin_ready low for 7 cycles, no sample skipped or duplicated.
REQ-038 Reset mid-operation: assert Rst_n=0 at MAC k=3 for one cycle -> no Yout_valid, Yout=0, Xin_ready=1 next cycle; the next impulse sees zero history.
REQ-039 Coefficient change during MAC: alter B0..B6 at k=2 -> result equals that computed with the coefficients latched at acceptance.
